conv_row_sequencer: RTL and testbench
=====================================

# conv_row_sequencer

Row-level scheduler for the 2D convolution engine. It sequences the one-dimensional convolution row unit (the column output-enable/accumulate path) across successive output rows. For each output row it clears the unit, fetches the kernel-height window of input rows from line memory through a request/acknowledge handshake, then enables the unit until it raises its output-full flag. Per-run configuration is supplied by the Nios control registers, and the block sits between that register file and the row datapath.

## Interface
Parameters:
- BITWIDTH_OF_ROWS, 11, width of row counts and row addresses
- BITWIDTH_STRIDE, 4, width of the vertical stride
- BITWIDTH_KERNEL, 4, width of the kernel-height field

Ports:
- CONV_ROWSEQ_Clk  in  1  single clock; all logic on rising edge
- CONV_ROWSEQ_Reset  in  1  synchronous, active-high reset
- CONV_ROWSEQ_Start  in  1  start pulse; ignored while Busy=1
- CONV_ROWSEQ_Of_Rows  in  BITWIDTH_OF_ROWS  number of output rows to produce
- CONV_ROWSEQ_Stride  in  BITWIDTH_STRIDE  vertical stride in input rows; 0 is treated as 1
- CONV_ROWSEQ_Kernel_Rows  in  BITWIDTH_KERNEL  kernel height; 0 is treated as 1
- CONV_ROWSEQ_Row_Ack  in  1  line memory accepted the current row fetch
- CONV_ROWSEQ_Flag_Out_Full  in  1  row unit has emitted all output columns
- CONV_ROWSEQ_Unit_Clr  out  1  active-low clear to the row unit
- CONV_ROWSEQ_Unit_En  out  1  enable to the row unit
- CONV_ROWSEQ_Row_Req  out  1  row fetch request
- CONV_ROWSEQ_Row_Addr  out  BITWIDTH_OF_ROWS  input row being fetched
- CONV_ROWSEQ_Row_Index  out  BITWIDTH_OF_ROWS  current output row
- CONV_ROWSEQ_Busy  out  1  a run is in progress
- CONV_ROWSEQ_Done  out  1  one-cycle end-of-run pulse

## Operation
- Configuration (Of_Rows, effective Stride, effective Kernel_Rows) is latched on an accepted Start. Later changes to the inputs have no effect until the next run.
- Internal registers:
  - base: first input row of the current window
  - k: fetch index within the window
  - row: output row counter
- All outputs are decoded from registered state and counters only (Moore). None depends combinationally on an input.
- States:
  - IDLE: Busy=0, Unit_Clr=1, Unit_En=0, Row_Req=0.
    - Start with Of_Rows≠0 → CLEAR; base=0, row=0.
    - Start with Of_Rows=0 → DONE directly.
  - CLEAR: Unit_Clr=0 for exactly one cycle; k=0 → FETCH.
  - FETCH: Row_Req=1, Row_Addr=base+k (modulo 2^BITWIDTH_OF_ROWS).
    - Ack=1 sampled: if k=Kernel_Rows−1 → RUN, otherwise k increments and the block stays in FETCH.
    - Ack=0: Req and Addr hold unchanged.
  - RUN: Unit_En=1, Row_Req=0. Flag_Out_Full=1 sampled → NEXT.
  - NEXT: Unit_En=0.
    - If row=Of_Rows−1 → DONE.
    - Otherwise row increments, base increments by Stride (wrapping) → CLEAR.
  - DONE: Done=1 for one cycle, Busy=0 → IDLE.
- Busy=1 in CLEAR, FETCH, RUN and NEXT.
- Row_Index equals row in every state. Row_Addr equals base+k in every state; its value outside FETCH carries no meaning.
- Flag_Out_Full asserted outside RUN is ignored.
- Row_Ack asserted outside FETCH is ignored.

## Timing
- Reset values (every output): Unit_Clr=1, Unit_En=0, Row_Req=0, Row_Addr=0, Row_Index=0, Busy=0, Done=0; state=IDLE.
- Reset asserted mid-run returns to IDLE on the next edge with those values. No Done is generated.
- Start sampled at edge n → CLEAR during cycle n+1 (Unit_Clr low, Busy high) → FETCH from cycle n+2.
- Ack may be high in the same cycle Req rises. The minimum fetch phase is Kernel_Rows cycles.
- Flag_Out_Full sampled at edge m → NEXT during m+1 → CLEAR (or DONE) during m+2.
- Per-row overhead: 1 (CLEAR) + Kernel_Rows (fetch, zero wait states) + 1 (NEXT) cycles, plus the RUN duration.
- Start and Reset high together: Reset wins.
- Start arriving in the same cycle as Done is ignored, because the block is not yet IDLE.
- The row unit clocks on the opposite edge. Unit_Clr and Unit_En are stable for a full cycle, so they are safely sampled mid-cycle.

## Test plan
- Reset then idle: hold Reset 3 cycles, then release with no Start → all outputs at reset values. Busy=0 and Done never pulses.
- Basic run: Of_Rows=3, Stride=1, Kernel_Rows=3, Ack tied 1, Flag_Out_Full pulsed 5 cycles after each RUN entry:
  - Row_Addr sequence is 0,1,2 / 1,2,3 / 2,3,4.
  - Exactly 3 single-cycle Unit_Clr low pulses.
  - One Done pulse, and Busy falls in the same cycle.
- Stride and wait states: Of_Rows=2, Stride=2, Kernel_Rows=2, Ack delayed 2 cycles per request:
  - Req and Addr are held until Ack.
  - Addresses are 0,1 / 2,3.
  - Row_Index goes 0 then 1.
- Degenerate config:
  - Of_Rows=0 → Done at cycle n+1, and Unit_Clr never goes low.
  - Stride=0, Kernel_Rows=0 → behaves exactly as 1 and 1.
- Start and flag hazards:
  - Start pulsed during RUN → ignored.
  - Flag_Out_Full held high during FETCH → no transition until RUN.
- Reset mid-run: assert Reset during the second FETCH → the next edge shows IDLE with reset values and no Done. A fresh Start restarts from Row_Addr=0.

Source files
------------

// File: rtl/conv_row_sequencer.sv
// Row-level scheduler for the 2D convolution engine: per output row it clears the
// row unit, fetches the kernel-height window of input rows, then runs the unit.
module conv_row_sequencer #(
  parameter int BITWIDTH_OF_ROWS = 11,
  parameter int BITWIDTH_STRIDE  = 4,
  parameter int BITWIDTH_KERNEL  = 4
) (
  input  logic                        CONV_ROWSEQ_Clk,
  input  logic                        CONV_ROWSEQ_Reset,
  input  logic                        CONV_ROWSEQ_Start,
  input  logic [BITWIDTH_OF_ROWS-1:0] CONV_ROWSEQ_Of_Rows,
  input  logic [BITWIDTH_STRIDE-1:0]  CONV_ROWSEQ_Stride,
  input  logic [BITWIDTH_KERNEL-1:0]  CONV_ROWSEQ_Kernel_Rows,
  input  logic                        CONV_ROWSEQ_Row_Ack,
  input  logic                        CONV_ROWSEQ_Flag_Out_Full,
  output logic                        CONV_ROWSEQ_Unit_Clr,
  output logic                        CONV_ROWSEQ_Unit_En,
  output logic                        CONV_ROWSEQ_Row_Req,
  output logic [BITWIDTH_OF_ROWS-1:0] CONV_ROWSEQ_Row_Addr,
  output logic [BITWIDTH_OF_ROWS-1:0] CONV_ROWSEQ_Row_Index,
  output logic                        CONV_ROWSEQ_Busy,
  output logic                        CONV_ROWSEQ_Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [BITWIDTH_OF_ROWS-1:0] ROW_ONE    = BITWIDTH_OF_ROWS'(1);
  localparam logic [BITWIDTH_STRIDE-1:0]  STRIDE_ONE = BITWIDTH_STRIDE'(1);
  localparam logic [BITWIDTH_KERNEL-1:0]  KERN_ONE   = BITWIDTH_KERNEL'(1);

  state_t state_q, state_d;

  // Run configuration, latched on an accepted Start (stride/kernel stored as effective values).
  logic [BITWIDTH_OF_ROWS-1:0] rows_q, rows_d;
  logic [BITWIDTH_STRIDE-1:0]  stride_q, stride_d;
  logic [BITWIDTH_KERNEL-1:0]  kern_q, kern_d;

  logic [BITWIDTH_OF_ROWS-1:0] base_q, base_d;
  logic [BITWIDTH_OF_ROWS-1:0] row_q, row_d;
  logic [BITWIDTH_KERNEL-1:0]  k_q, k_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CONV_ROWSEQ_Clk) begin
    if (CONV_ROWSEQ_Reset) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      stride_q <= STRIDE_ONE;
      kern_q   <= KERN_ONE;
      base_q   <= '0;
      row_q    <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      stride_q <= stride_d;
      kern_q   <= kern_d;
      base_q   <= base_d;
      row_q    <= row_d;
      k_q      <= k_d;
    end
  end

  // NOTE: every variable gets a hold default up front so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    stride_d = stride_q;
    kern_d   = kern_q;
    base_d   = base_q;
    row_d    = row_q;
    k_d      = k_q;

    unique case (state_q)
      S_IDLE: begin
        if (CONV_ROWSEQ_Start) begin
          rows_d   = CONV_ROWSEQ_Of_Rows;
          stride_d = (CONV_ROWSEQ_Stride == '0) ? STRIDE_ONE : CONV_ROWSEQ_Stride;
          kern_d   = (CONV_ROWSEQ_Kernel_Rows == '0) ? KERN_ONE : CONV_ROWSEQ_Kernel_Rows;
          base_d   = '0;
          row_d    = '0;
          k_d      = '0;
          state_d  = (CONV_ROWSEQ_Of_Rows == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (CONV_ROWSEQ_Row_Ack) begin
          if (k_q == kern_q - KERN_ONE) state_d = S_RUN;
          else                          k_d     = k_q + KERN_ONE;
        end
      end
      S_RUN: begin
        if (CONV_ROWSEQ_Flag_Out_Full) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (row_q == rows_q - ROW_ONE) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ROW_ONE;
          base_d  = base_q + BITWIDTH_OF_ROWS'(stride_q);
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state and counters only.
  always_comb begin
    CONV_ROWSEQ_Unit_Clr  = (state_q != S_CLEAR);
    CONV_ROWSEQ_Unit_En   = (state_q == S_RUN);
    CONV_ROWSEQ_Row_Req   = (state_q == S_FETCH);
    CONV_ROWSEQ_Row_Addr  = base_q + BITWIDTH_OF_ROWS'(k_q);
    CONV_ROWSEQ_Row_Index = row_q;
    CONV_ROWSEQ_Busy      = (state_q == S_CLEAR) || (state_q == S_FETCH) ||
                            (state_q == S_RUN)   || (state_q == S_NEXT);
    CONV_ROWSEQ_Done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Bench for conv_row_sequencer: table of run configurations checked through a
// fetch scoreboard, plus hand sequences for reset/start hazards.
module tb_conv_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] of_rows;
  logic [3:0]  stride;
  logic [3:0]  kern;
  logic        ack;
  logic        full;
  logic        unit_clr, unit_en, row_req, busy, done;
  logic [10:0] row_addr, row_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_row_sequencer dut (
    .CONV_ROWSEQ_Clk           (clk),
    .CONV_ROWSEQ_Reset         (rst),
    .CONV_ROWSEQ_Start         (start),
    .CONV_ROWSEQ_Of_Rows       (of_rows),
    .CONV_ROWSEQ_Stride        (stride),
    .CONV_ROWSEQ_Kernel_Rows   (kern),
    .CONV_ROWSEQ_Row_Ack       (ack),
    .CONV_ROWSEQ_Flag_Out_Full (full),
    .CONV_ROWSEQ_Unit_Clr      (unit_clr),
    .CONV_ROWSEQ_Unit_En       (unit_en),
    .CONV_ROWSEQ_Row_Req       (row_req),
    .CONV_ROWSEQ_Row_Addr      (row_addr),
    .CONV_ROWSEQ_Row_Index     (row_index),
    .CONV_ROWSEQ_Busy          (busy),
    .CONV_ROWSEQ_Done          (done)
  );

  typedef struct {
    int of_rows;
    int stride;
    int kern;
    int ack_delay;
    int full_delay;
    bit flag_in_fetch;
    bit start_in_run;
    bit start_at_done;
    int exp_clr;
    int exp_cycles;
  } vec_t;

  typedef struct packed {
    logic [10:0] addr;
    logic [10:0] row;
  } fetch_t;

  fetch_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_clr"},   {31'd0, unit_clr}, 32'd1);
    check({tag, "_en"},    {31'd0, unit_en},  32'd0);
    check({tag, "_req"},   {31'd0, row_req},  32'd0);
    check({tag, "_addr"},  {21'd0, row_addr}, 32'd0);
    check({tag, "_index"}, {21'd0, row_index}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_done"},  {31'd0, done},     32'd0);
  endtask

  // One complete run; outputs are sampled and inputs driven on the falling edge.
  task automatic do_run(input vec_t v);
    int se, ke, cyc, clr, waitc, enc;
    bit seen_done, pend;
    logic [10:0] held;
    fetch_t f;
    se = (v.stride == 0) ? 1 : v.stride;
    ke = (v.kern == 0) ? 1 : v.kern;
    exp_q.delete();
    for (int r = 0; r < v.of_rows; r++)
      for (int k = 0; k < ke; k++)
        exp_q.push_back('{addr: 11'(r * se + k), row: 11'(r)});

    @(negedge clk);
    start   = 1'b1;
    of_rows = 11'(v.of_rows);
    stride  = 4'(v.stride);
    kern    = 4'(v.kern);
    @(negedge clk);
    start   = 1'b0;
    // Scramble config: it must have been latched already.
    of_rows = 11'($urandom_range(1, 2047));
    stride  = 4'($urandom);
    kern    = 4'($urandom);
    if (v.of_rows != 0) begin
      check("start_clear_clr",  {31'd0, unit_clr}, 32'd0);
      check("start_clear_busy", {31'd0, busy},     32'd1);
    end

    cyc = 0; clr = 0; waitc = 0; enc = 0; seen_done = 0; pend = 0; held = '0;
    while (!seen_done && cyc < 2000) begin
      cyc++;
      start = 1'b0;
      ack   = 1'b0;
      full  = 1'b0;
      if (!unit_clr) clr++;
      if (row_req) begin
        if (pend) check("fetch_addr_held", {21'd0, row_addr}, {21'd0, held});
        held = row_addr;
        pend = 1'b1;
        if (v.flag_in_fetch) full = 1'b1;
        if (waitc == v.ack_delay) begin
          ack   = 1'b1;
          waitc = 0;
          pend  = 1'b0;
          if (exp_q.size() == 0) begin
            check("fetch_unexpected", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            check("fetch_addr",  {21'd0, row_addr},  {21'd0, f.addr});
            check("fetch_index", {21'd0, row_index}, {21'd0, f.row});
          end
        end else begin
          waitc++;
        end
      end
      if (unit_en) begin
        enc++;
        if (v.start_in_run && enc == 1) start = 1'b1;
        if (enc == v.full_delay) begin
          full = 1'b1;
          enc  = 0;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_busy_low", {31'd0, busy}, 32'd0);
        check("run_cycles",    cyc,           v.exp_cycles);
        check("clr_pulses",    clr,           v.exp_clr);
        check("fetch_left",    exp_q.size(),  0);
        if (v.start_at_done) start = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen_done) check("run_timeout", 32'd1, 32'd0);
    @(negedge clk);
    start = 1'b0;
    full  = 1'b0;
    ack   = 1'b0;
    check("after_done_busy", {31'd0, busy},     32'd0);
    check("after_done_done", {31'd0, done},     32'd0);
    check("after_done_clr",  {31'd0, unit_clr}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    // {rows, stride, kern, ack_delay, full_delay, flag_in_fetch, start_in_run, start_at_done, clr, cycles}
    vecs[0] = '{3,  1,  3, 0, 5, 1'b0, 1'b0, 1'b0, 3, 31};
    vecs[1] = '{2,  2,  2, 2, 3, 1'b0, 1'b0, 1'b1, 2, 23};
    vecs[2] = '{0,  1,  3, 0, 5, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[3] = '{2,  0,  0, 0, 2, 1'b0, 1'b0, 1'b0, 2, 11};
    vecs[4] = '{1,  1,  4, 1, 2, 1'b1, 1'b0, 1'b0, 1, 13};
    vecs[5] = '{2,  3,  2, 0, 4, 1'b0, 1'b1, 1'b0, 2, 17};
    vecs[6] = '{3, 15, 15, 0, 1, 1'b0, 1'b0, 1'b0, 3, 55};

    rst = 1'b1; start = 1'b1; of_rows = 11'd3; stride = 4'd1; kern = 4'd3;
    ack = 1'b0; full = 1'b0;

    // Reset held 3 cycles with Start also high: reset wins.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    for (int i = 0; i < 7; i++) do_run(vecs[i]);

    // Reset during the second FETCH of a run.
    begin
      bit hit;
      hit = 1'b0;
      @(negedge clk);
      start = 1'b1; of_rows = 11'd3; stride = 4'd1; kern = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        if (row_req && row_index == 11'd1) begin
          hit = 1'b1;
        end else begin
          ack  = row_req;
          full = unit_en;
          @(negedge clk);
        end
      end
      check("reach_second_fetch", {31'd0, hit}, 32'd1);
      ack = 1'b0; full = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_idle("midrun_reset");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_idle("post_reset");
      end
      exp_q.delete();
    end
    do_run(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
